// File: rtl/piradip_axi4_burst_mgr_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi4mm
//  Purpose  : AXI4 memory-mapped bundle (all five channels, full signal set).
//             MANAGER drives AW/W/AR and the B/R ready lines; SUBORDINATE
//             is the mirror image.
//  Params   : ADDR_WIDTH, DATA_WIDTH, ID_WIDTH, USER_WIDTH
//  Revision : 1.0  initial release
// ============================================================================
interface axi4mm #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1,
    parameter int USER_WIDTH = 1
);
    // Write address channel
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic [3:0]              awregion;
    logic [USER_WIDTH-1:0]   awuser;
    logic                    awvalid;
    logic                    awready;
    // Write data channel
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic [USER_WIDTH-1:0]   wuser;
    logic                    wvalid;
    logic                    wready;
    // Write response channel
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic [USER_WIDTH-1:0]   buser;
    logic                    bvalid;
    logic                    bready;
    // Read address channel
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic [3:0]              arregion;
    logic [USER_WIDTH-1:0]   aruser;
    logic                    arvalid;
    logic                    arready;
    // Read data channel
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic [USER_WIDTH-1:0]   ruser;
    logic                    rvalid;
    logic                    rready;

    modport MANAGER (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awqos, awregion, awuser, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wuser, wvalid,
        input  wready,
        input  bid, bresp, buser, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arqos, arregion, aruser, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, ruser, rvalid,
        output rready
    );

    modport SUBORDINATE (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awqos, awregion, awuser, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wuser, wvalid,
        output wready,
        output bid, bresp, buser, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arqos, arregion, aruser, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, ruser, rvalid,
        input  rready
    );
endinterface
`default_nettype wire

// File: rtl/piradip_axi4_burst_mgr.sv
`default_nettype none
// ============================================================================
//  Module   : piradip_axi4_burst_mgr
//  Purpose  : Single-outstanding AXI4 manager. One command (addr, len, burst,
//             direction) becomes one AXI4 burst. Write beats stream in on
//             wr_*, read beats stream out on rd_*; done pulses for one cycle
//             with the AXI response of the finished command.
//  Ports    : clk, resetn (async, active-low)
//             cmd_*  : command handshake (valid/ready)
//             wr_*   : write beat source (valid/ready)
//             rd_*   : read beat sink (valid/ready), rd_last on final beat
//             done, done_resp : completion pulse and response
//             aximm  : axi4mm.MANAGER
//  Revision : 1.0  initial release
// ============================================================================
module piradip_axi4_burst_mgr #(
    parameter int                  ADDR_WIDTH = 32,
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ID_WIDTH   = 1,
    parameter logic [ID_WIDTH-1:0] TXN_ID     = '0
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]              cmd_len,
    input  logic [1:0]              cmd_burst,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_last,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic                    done,
    output logic [1:0]              done_resp,
    axi4mm.MANAGER                  aximm
);

    localparam logic [2:0] c_AXSIZE  = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [3:0] c_AXCACHE = 4'b0011;
    localparam logic [1:0] c_OKAY    = 2'b00;
    localparam logic [1:0] c_SLVERR  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_AR   = 3'd4,
        S_R    = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;
    logic [7:0]              len_q,   len_d;
    logic [1:0]              burst_q, burst_d;
    logic [7:0]              cnt_q,   cnt_d;
    logic [1:0]              acc_q,   acc_d;
    logic [1:0]              resp_q,  resp_d;

    logic                    w_is_last;
    logic                    w_wbeat;
    logic                    w_rbeat;
    logic [1:0]              w_acc_beat;

    assign w_is_last = (cnt_q == len_q);
    assign w_wbeat   = (state_q == S_W) && wr_valid && aximm.wready;
    assign w_rbeat   = (state_q == S_R) && aximm.rvalid && rd_ready;

    // Response accumulation for the current read beat: worst response wins
    // (the AXI encoding is ordered by severity), and an rlast that disagrees
    // with the beat count replaces it with SLVERR.
    always_comb begin
        w_acc_beat = (aximm.rresp > acc_q) ? aximm.rresp : acc_q;
        if (aximm.rlast != w_is_last) begin
            w_acc_beat = c_SLVERR;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        burst_d = burst_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        resp_d  = resp_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    burst_d = cmd_burst;
                    cnt_d   = 8'd0;
                    acc_d   = c_OKAY;
                    state_d = cmd_write ? S_AW : S_AR;
                end
            end
            S_AW: begin
                if (aximm.awready) begin
                    state_d = S_W;
                end
            end
            S_W: begin
                if (w_wbeat) begin
                    // Counter holds at len on the last beat so len=255
                    // never wraps.
                    if (w_is_last) begin
                        state_d = S_B;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_B: begin
                if (aximm.bvalid) begin
                    resp_d  = aximm.bresp;
                    state_d = S_DONE;
                end
            end
            S_AR: begin
                if (aximm.arready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                if (w_rbeat) begin
                    acc_d = w_acc_beat;
                    if (w_is_last) begin
                        resp_d  = w_acc_beat;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= 8'd0;
            burst_q <= 2'd0;
            cnt_q   <= 8'd0;
            acc_q   <= c_OKAY;
            resp_q  <= c_OKAY;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            resp_q  <= resp_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all decoded from the registered state, so an asynchronous
    // reset drops every valid/ready immediately.
    // ------------------------------------------------------------------
    assign cmd_ready = (state_q == S_IDLE);
    assign done      = (state_q == S_DONE);
    assign done_resp = resp_q;

    // Write source <-> W channel pass-through
    assign aximm.wvalid = (state_q == S_W) && wr_valid;
    assign wr_ready     = (state_q == S_W) && aximm.wready;
    assign aximm.wdata  = (state_q == S_W) ? wr_data : '0;
    assign aximm.wstrb  = (state_q == S_W) ? wr_strb : '0;
    assign aximm.wlast  = (state_q == S_W) && w_is_last;
    assign aximm.wuser  = '0;

    // R channel <-> read sink pass-through
    assign rd_valid     = (state_q == S_R) && aximm.rvalid;
    assign aximm.rready = (state_q == S_R) && rd_ready;
    assign rd_data      = (state_q == S_R) ? aximm.rdata : '0;
    assign rd_last      = (state_q == S_R) && w_is_last;

    assign aximm.bready = (state_q == S_B);

    // Write address channel
    assign aximm.awvalid  = (state_q == S_AW);
    assign aximm.awid     = TXN_ID;
    assign aximm.awaddr   = addr_q;
    assign aximm.awlen    = len_q;
    assign aximm.awsize   = c_AXSIZE;
    assign aximm.awburst  = burst_q;
    assign aximm.awlock   = 1'b0;
    assign aximm.awcache  = c_AXCACHE;
    assign aximm.awprot   = 3'd0;
    assign aximm.awqos    = 4'd0;
    assign aximm.awregion = 4'd0;
    assign aximm.awuser   = '0;

    // Read address channel
    assign aximm.arvalid  = (state_q == S_AR);
    assign aximm.arid     = TXN_ID;
    assign aximm.araddr   = addr_q;
    assign aximm.arlen    = len_q;
    assign aximm.arsize   = c_AXSIZE;
    assign aximm.arburst  = burst_q;
    assign aximm.arlock   = 1'b0;
    assign aximm.arcache  = c_AXCACHE;
    assign aximm.arprot   = 3'd0;
    assign aximm.arqos    = 4'd0;
    assign aximm.arregion = 4'd0;
    assign aximm.aruser   = '0;

    // IDs and user sidebands returned by the subordinate carry no meaning
    // for a single-outstanding manager with a fixed ID.
    logic w_unused;
    assign w_unused = ^{aximm.bid, aximm.buser, aximm.rid, aximm.ruser};

endmodule
`default_nettype wire

// File: tb/tb_piradip_axi4_burst_mgr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_piradip_axi4_burst_mgr
//  Purpose  : Directed self-checking bench. The bench plays the AXI
//             subordinate, the write source and the read sink.
//  Revision : 1.0  initial release
// ============================================================================
module tb_piradip_axi4_burst_mgr;

    logic        clk;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [1:0]  cmd_burst;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        rd_valid;
    logic        rd_ready;
    logic        done;
    logic [1:0]  done_resp;

    int tests  = 0;
    int failed = 0;

    axi4mm #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(1), .USER_WIDTH(1)) bus ();

    piradip_axi4_burst_mgr #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(1), .TXN_ID(1'b0)
    ) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_burst(cmd_burst),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done(done), .done_resp(done_resp),
        .aximm(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_drives();
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_burst = 0;
        wr_data = 0; wr_strb = 0; wr_valid = 0; rd_ready = 0;
        bus.awready = 0; bus.wready = 0;
        bus.bid = 0; bus.bresp = 0; bus.buser = 0; bus.bvalid = 0;
        bus.arready = 0;
        bus.rid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 0; bus.ruser = 0; bus.rvalid = 0;
    endtask

    task automatic test_reset();
        resetn = 0;
        clear_drives();
        #12;
        tests++;
        if ({cmd_ready, wr_ready, rd_valid, rd_last, done, done_resp} !== 7'b1000000) begin
            $display("FAIL reset_outputs: got {cmd_ready,wr_ready,rd_valid,rd_last,done,done_resp}=%b want 1000000",
                     {cmd_ready, wr_ready, rd_valid, rd_last, done, done_resp});
            failed++;
        end
        tests++;
        if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 5'b0) begin
            $display("FAIL reset_axi: got {awvalid,wvalid,bready,arvalid,rready}=%b want 00000",
                     {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready});
            failed++;
        end
        tests++;
        if ({bus.awsize, bus.arsize, bus.awcache, bus.arcache, bus.awlock, bus.arlock} !== 16'b010_010_0011_0011_0_0) begin
            $display("FAIL static_fields: got size/cache/lock=%b want 0100100011001100",
                     {bus.awsize, bus.arsize, bus.awcache, bus.arcache, bus.awlock, bus.arlock});
            failed++;
        end
        @(negedge clk);
        resetn = 1;
        step();
    endtask

    // Write burst: AW accepted after one wait cycle, each W beat preceded by
    // `gap` cycles of wready low, data 0xA0+i, response `bresp`.
    task automatic test_write(input logic [31:0] addr, input int len, input int gap,
                              input logic [1:0] bresp);
        logic [31:0] exp_data;
        cmd_valid = 1; cmd_write = 1; cmd_addr = addr; cmd_len = 8'(len); cmd_burst = 2'd1;
        #1;
        tests++;
        if (cmd_ready !== 1'b1) begin
            $display("FAIL wr_cmd_ready: got %b want 1", cmd_ready); failed++;
        end
        step();
        cmd_valid = 0;
        wr_valid  = 1; wr_data = 32'hA0; wr_strb = 4'h0;
        #1;
        tests++;
        if ({bus.awvalid, bus.awaddr, bus.awlen, bus.awsize, bus.awburst, bus.awid}
            !== {1'b1, addr, 8'(len), 3'd2, 2'd1, 1'b0}) begin
            $display("FAIL aw_fields: got valid=%b addr=%h len=%0d size=%0d burst=%0d id=%0d want 1 %h %0d 2 1 0",
                     bus.awvalid, bus.awaddr, bus.awlen, bus.awsize, bus.awburst, bus.awid, addr, len);
            failed++;
        end
        tests++;
        if ({bus.wvalid, wr_ready} !== 2'b00) begin
            $display("FAIL w_before_aw: got wvalid,wr_ready=%b want 00", {bus.wvalid, wr_ready}); failed++;
        end
        step();
        tests++;
        if ({bus.awvalid, bus.awaddr} !== {1'b1, addr}) begin
            $display("FAIL aw_hold: got valid=%b addr=%h want 1 %h", bus.awvalid, bus.awaddr, addr); failed++;
        end
        bus.awready = 1;
        step();
        bus.awready = 0;
        #1;
        tests++;
        if (bus.awvalid !== 1'b0) begin
            $display("FAIL aw_drop: got awvalid=%b want 0", bus.awvalid); failed++;
        end
        for (int i = 0; i <= len; i++) begin
            exp_data = 32'hA0 + 32'(i);
            wr_data  = exp_data;
            wr_strb  = 4'(i);
            for (int g = 0; g < gap; g++) begin
                bus.wready = 0;
                #1;
                tests++;
                if ({bus.wvalid, wr_ready, bus.wdata} !== {1'b1, 1'b0, exp_data}) begin
                    $display("FAIL w_stall beat %0d: got wvalid=%b wr_ready=%b wdata=%h want 1 0 %h",
                             i, bus.wvalid, wr_ready, bus.wdata, exp_data);
                    failed++;
                end
                step();
            end
            bus.wready = 1;
            #1;
            tests++;
            if ({bus.wvalid, wr_ready, bus.wdata, bus.wstrb, bus.wlast}
                !== {1'b1, 1'b1, exp_data, 4'(i), (i == len)}) begin
                $display("FAIL w_beat %0d: got wvalid=%b wr_ready=%b wdata=%h wstrb=%h wlast=%b want 1 1 %h %h %b",
                         i, bus.wvalid, wr_ready, bus.wdata, bus.wstrb, bus.wlast, exp_data, 4'(i), (i == len));
                failed++;
            end
            step();
        end
        bus.wready = 0;
        wr_valid   = 0;
        #1;
        tests++;
        if ({bus.wvalid, bus.bready, done} !== 3'b010) begin
            $display("FAIL b_wait: got wvalid,bready,done=%b want 010", {bus.wvalid, bus.bready, done}); failed++;
        end
        bus.bvalid = 1; bus.bresp = bresp;
        step();
        bus.bvalid = 0; bus.bresp = 0;
        #1;
        tests++;
        if ({done, done_resp, bus.bready} !== {1'b1, bresp, 1'b0}) begin
            $display("FAIL wr_done: got done=%b resp=%b bready=%b want 1 %b 0", done, done_resp, bus.bready, bresp);
            failed++;
        end
        step();
        tests++;
        if ({done, cmd_ready, done_resp} !== {1'b0, 1'b1, bresp}) begin
            $display("FAIL wr_after_done: got done=%b cmd_ready=%b resp=%b want 0 1 %b", done, cmd_ready, done_resp, bresp);
            failed++;
        end
    endtask

    // Read burst: beat k returns base+k; err_beat (0-based) carries err_resp;
    // rlast follows the beat count unless early_last >= 0, in which case it
    // is asserted only on that beat. toggle alternates rd_ready starting low.
    task automatic test_read(input logic [31:0] addr, input int len, input logic [31:0] base,
                             input int err_beat, input logic [1:0] err_resp,
                             input int early_last, input bit toggle, input logic [1:0] exp_resp);
        int k;
        int c;
        logic [31:0] exp_data;
        cmd_valid = 1; cmd_write = 0; cmd_addr = addr; cmd_len = 8'(len); cmd_burst = 2'd1;
        step();
        cmd_valid = 0;
        #1;
        tests++;
        if ({bus.arvalid, bus.araddr, bus.arlen, bus.arsize, bus.arburst, bus.awvalid}
            !== {1'b1, addr, 8'(len), 3'd2, 2'd1, 1'b0}) begin
            $display("FAIL ar_fields: got valid=%b addr=%h len=%0d size=%0d burst=%0d awvalid=%b want 1 %h %0d 2 1 0",
                     bus.arvalid, bus.araddr, bus.arlen, bus.arsize, bus.arburst, bus.awvalid, addr, len);
            failed++;
        end
        step();
        tests++;
        if ({bus.arvalid, bus.araddr, rd_valid} !== {1'b1, addr, 1'b0}) begin
            $display("FAIL ar_hold: got valid=%b addr=%h rd_valid=%b want 1 %h 0", bus.arvalid, bus.araddr, rd_valid, addr);
            failed++;
        end
        bus.arready = 1;
        step();
        bus.arready = 0;
        #1;
        tests++;
        if (bus.arvalid !== 1'b0) begin
            $display("FAIL ar_drop: got arvalid=%b want 0", bus.arvalid); failed++;
        end
        k = 0;
        c = 0;
        while (k <= len && c < 200) begin
            exp_data    = base + 32'(k);
            rd_ready    = toggle ? c[0] : 1'b1;
            bus.rvalid  = 1;
            bus.rdata   = exp_data;
            bus.rresp   = (k == err_beat) ? err_resp : 2'b00;
            bus.rlast   = (early_last >= 0) ? (k == early_last) : (k == len);
            #1;
            tests++;
            if ({rd_valid, rd_data, rd_last, bus.rready} !== {1'b1, exp_data, (k == len), rd_ready}) begin
                $display("FAIL r_beat %0d: got rd_valid=%b rd_data=%h rd_last=%b rready=%b want 1 %h %b %b",
                         k, rd_valid, rd_data, rd_last, bus.rready, exp_data, (k == len), rd_ready);
                failed++;
            end
            step();
            if (rd_ready) k++;
            c++;
        end
        if (c >= 200) begin
            tests++;
            failed++;
            $display("FAIL r_timeout: got %0d beats want %0d", k, len + 1);
        end
        bus.rvalid = 0; bus.rlast = 0; bus.rresp = 0;
        rd_ready   = 0;
        #1;
        tests++;
        if ({done, done_resp, rd_valid} !== {1'b1, exp_resp, 1'b0}) begin
            $display("FAIL rd_done: got done=%b resp=%b rd_valid=%b want 1 %b 0", done, done_resp, rd_valid, exp_resp);
            failed++;
        end
        step();
        tests++;
        if ({done, cmd_ready, done_resp} !== {1'b0, 1'b1, exp_resp}) begin
            $display("FAIL rd_after_done: got done=%b cmd_ready=%b resp=%b want 0 1 %b", done, cmd_ready, done_resp, exp_resp);
            failed++;
        end
    endtask

    task automatic test_reset_mid_burst();
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h400; cmd_len = 8'd7; cmd_burst = 2'd1;
        step();
        cmd_valid = 0;
        bus.awready = 1;
        step();
        bus.awready = 0;
        wr_valid = 1; wr_data = 32'h11; wr_strb = 4'hF; bus.wready = 1;
        step();
        wr_data = 32'h22; bus.wready = 0;
        #1;
        tests++;
        if ({bus.wvalid, bus.wdata} !== {1'b1, 32'h22}) begin
            $display("FAIL rst_beat2: got wvalid=%b wdata=%h want 1 00000022", bus.wvalid, bus.wdata); failed++;
        end
        resetn = 0;
        #1;
        tests++;
        if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, done, wr_ready, rd_valid, cmd_ready, done_resp}
            !== 11'b00000000100) begin
            $display("FAIL rst_async: got aw,w,b,ar,r,done,wr_ready,rd_valid,cmd_ready,resp=%b want 00000000100",
                     {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, done, wr_ready, rd_valid, cmd_ready, done_resp});
            failed++;
        end
        #1;
        clear_drives();
        resetn = 1;
        step();
        tests++;
        if ({cmd_ready, bus.awvalid, bus.wvalid} !== 3'b100) begin
            $display("FAIL rst_release: got cmd_ready,awvalid,wvalid=%b want 100", {cmd_ready, bus.awvalid, bus.wvalid});
            failed++;
        end
        test_read(32'h500, 1, 32'h5A5A0000, -1, 2'b00, -1, 1'b0, 2'b00);
    endtask

    initial begin
        test_reset();
        // 1: write len=3 INCR, 2-cycle wready gaps, OKAY
        test_write(32'h100, 3, 2, 2'b00);
        // 2: single-beat read, rlast correct, OKAY
        test_read(32'h200, 0, 32'hDEADBEEF, -1, 2'b00, -1, 1'b0, 2'b00);
        // 3: len=7, rd_ready toggling, SLVERR on 4th beat
        test_read(32'h1000, 7, 32'h3000, 3, 2'b10, -1, 1'b1, 2'b10);
        // 4: len=3, rlast early on 2nd beat
        test_read(32'h2000, 3, 32'h4000, -1, 2'b00, 1, 1'b0, 2'b10);
        // 5: 256-beat write, DECERR
        test_write(32'h0, 255, 0, 2'b11);
        // 6: reset during 2nd W beat, then a fresh read
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want $finish before 500000");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
